// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Covers stall patterns, stage control levels, the default exception vector, FSM states and the stall encoder.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

  // The deepest requester wins. Each pattern freezes every stage behind the requester.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] pat;
    pat = STALL_NONE;
    if (req_mem)     pat = STALL_MEM;
    else if (req_ex) pat = STALL_EX;
    else if (req_id) pat = STALL_ID;
    else if (req_if) pat = STALL_IF;
    return pat;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_monitor.sv
// Stall duration tracking: consecutive-stall watchdog plus saturating total stall count.
// Latency: one cycle from a stalled cycle to the counter and trip update. There is no backpressure.
module stall_monitor #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_any,
  input  logic        in_flush,
  output logic        wdog_trip,
  output logic [31:0] stall_cycles
);

  logic [15:0] run_cnt;
  logic [31:0] run_inc;

  assign run_inc = {16'd0, run_cnt} + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt      <= 16'd0;
      wdog_trip    <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      if (!stall_any || in_flush) begin
        run_cnt <= 16'd0;
      end else if (run_cnt != 16'hFFFF) begin
        run_cnt <= run_cnt + 16'd1;
      end

      // The trip flag sets on the same edge at which the run counter reaches the limit.
      if (stall_any && !in_flush && run_inc >= WDOG_LIMIT) begin
        wdog_trip <= 1'b1;
      end

      if (stall_any && stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Merges the stage stall requests into a contiguous stall vector and sequences the exception and eret flush.
// Stall has zero latency. Flush and new_pc are valid one cycle after the exception is sampled. There is no backpressure.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_is_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_trip,
  output logic [31:0] stall_cycles
);

  ctrl_state_t state_q, state_d;
  logic [5:0]  stall_raw;
  logic        latch_pc;
  logic [31:0] new_pc_q;

  always_comb begin
    state_d   = state_q;
    stall_raw = STALL_NONE;
    latch_pc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An exception beats every stall. The data-bus owner cancels on flush.
        if (except_valid) begin
          state_d  = ST_FLUSH;
          latch_pc = 1'b1;
        end else begin
          stall_raw = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      ST_FLUSH: begin
        // Requests issued in this cycle come from instructions that are being flushed.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      new_pc_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (latch_pc) begin
        new_pc_q <= except_is_eret ? cp0_epc : EXC_VECTOR;
      end
    end
  end

  assign stall  = reset ? stall_raw : {6{NoStop}};
  assign flush  = (state_q == ST_FLUSH);
  assign new_pc = new_pc_q;

  stall_monitor #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_stall_monitor (
    .clk          (clk),
    .reset        (reset),
    .stall_any    (stall[0] == Stop),
    .in_flush     (flush),
    .wdog_trip    (wdog_trip),
    .stall_cycles (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with WDOG_LIMIT reduced to 8.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid, except_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_trip;
  logic [31:0] stall_cycles;

  int vectors    = 0;
  int miscompares = 0;

  pipe_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .WDOG_LIMIT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .except_valid   (except_valid),
    .except_is_eret (except_is_eret),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .wdog_trip      (wdog_trip),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    except_valid = 0; except_is_eret = 0;
  endtask

  initial begin
    // Reset is held with every request and an exception asserted.
    reset = 0;
    stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    except_valid = 1; except_is_eret = 1; cp0_epc = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_wdog", {31'd0, wdog_trip}, 32'h0);
    clear_inputs();
    @(negedge clk) reset = 1;

    // Priority encoding is combinational and resolves within one cycle.
    step();
    stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; #1;
    chk("prio_if_id_ex", {26'd0, stall}, 32'h0F);
    stallreq_mem = 1; #1;
    chk("prio_all", {26'd0, stall}, 32'h1F);
    clear_inputs(); #1;
    chk("prio_release", {26'd0, stall}, 32'h00);
    stallreq_id = 1; #1;
    chk("prio_id", {26'd0, stall}, 32'h07);
    stallreq_id = 0; stallreq_if = 1; #1;
    chk("prio_if", {26'd0, stall}, 32'h03);
    step();
    stallreq_if = 0;
    chk("count_one", stall_cycles, 32'd1);

    // An exception with a concurrent memory stall jumps to the exception vector.
    step();
    except_valid = 1; stallreq_mem = 1; #1;
    chk("exc_stall_zero", {26'd0, stall}, 32'h0);
    step();
    except_valid = 0;
    chk("exc_flush_n1", {31'd0, flush}, 32'h1);
    chk("exc_new_pc", new_pc, 32'hBFC0_0380);
    chk("flush_stall_zero", {26'd0, stall}, 32'h0);
    stallreq_mem = 0;
    step();
    chk("exc_flush_n2", {31'd0, flush}, 32'h0);
    chk("exc_new_pc_hold", new_pc, 32'hBFC0_0380);
    chk("exc_no_count", stall_cycles, 32'd1);

    // An eret redirects to the EPC.
    except_valid = 1; except_is_eret = 1; cp0_epc = 32'h8000_1234;
    step();
    clear_inputs();
    chk("eret_flush", {31'd0, flush}, 32'h1);
    chk("eret_new_pc", new_pc, 32'h8000_1234);
    step();
    chk("eret_flush_end", {31'd0, flush}, 32'h0);

    // An exception held for three cycles is ignored during the flush cycle.
    except_valid = 1;
    step();
    chk("shadow_n1", {31'd0, flush}, 32'h1);
    step();
    chk("shadow_n2", {31'd0, flush}, 32'h0);
    step();
    except_valid = 0;
    chk("shadow_n3", {31'd0, flush}, 32'h1);
    chk("shadow_pc", new_pc, 32'hBFC0_0380);
    step();
    chk("shadow_n4", {31'd0, flush}, 32'h0);

    // Watchdog: a run of 7 stalled cycles does not trip it, but a run of 8 does.
    stallreq_ex = 1;
    repeat (7) step();
    stallreq_ex = 0;
    chk("wdog_7_no_trip", {31'd0, wdog_trip}, 32'h0);
    chk("count_after_7", stall_cycles, 32'd8);
    step();
    stallreq_ex = 1;
    repeat (8) step();
    stallreq_ex = 0;
    chk("wdog_8_trip", {31'd0, wdog_trip}, 32'h1);
    step();
    step();
    chk("wdog_sticky", {31'd0, wdog_trip}, 32'h1);
    chk("count_total", stall_cycles, 32'd16);

    // Reset asserted during the flush cycle aborts it immediately.
    except_valid = 1;
    step();
    except_valid = 0;
    chk("mid_flush_active", {31'd0, flush}, 32'h1);
    #2 reset = 0;
    #1;
    chk("mid_rst_flush", {31'd0, flush}, 32'h0);
    chk("mid_rst_pc", new_pc, 32'h0);
    chk("mid_rst_wdog", {31'd0, wdog_trip}, 32'h0);
    chk("mid_rst_count", stall_cycles, 32'h0);
    @(negedge clk) reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_flush", {31'd0, flush}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the five-stage MIPS core. It merges per-stage stall requests into the contiguous `stall[5:0]` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences exception/eret flushes and supplies the redirect PC. It also tracks stall duration for a hang watchdog and a performance counter.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: exception handler entry PC.
- `WDOG_LIMIT`, default 1024: consecutive stalled cycles before watchdog trips.
- `clk` in 1: core clock.
- `reset` in 1: reset, asynchronous, active-low.
- `stallreq_if` in 1: instruction bus not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle divide busy.
- `stallreq_mem` in 1: data bus not ready.
- `except_valid` in 1: MEM-stage instruction raises exception or eret (from MEM except word ≠ 0).
- `except_is_eret` in 1: qualifies `except_valid`; 1 = eret.
- `cp0_epc` in 32: current EPC from CP0.
- `stall` out 6: bit0 PC … bit5 WB; 1 = Stop.
- `flush` out 1: clear all pipeline registers this cycle.
- `new_pc` out 32: redirect target, valid when `flush`=1.
- `wdog_trip` out 1: sticky watchdog error.
- `stall_cycles` out 32: saturating count of cycles with `stall`≠0.

## Operation
- States: IDLE, FLUSH. Register the state; reset value IDLE.
- IDLE, `except_valid`=1:
  - `stall`=0. The exception overrides all stall requests, including `stallreq_mem`.
  - The next state is FLUSH.
  - Latch `new_pc` = `cp0_epc` if `except_is_eret`, else `EXC_VECTOR`.
- IDLE, no exception: `stall` is driven from the highest-priority request.
  - `stallreq_mem`: 6'b011111.
  - Else `stallreq_ex`: 6'b001111.
  - Else `stallreq_id`: 6'b000111.
  - Else `stallreq_if`: 6'b000011.
  - Else 6'b000000.
- FLUSH: `flush`=1 for exactly one cycle and `stall`=0. All requests and `except_valid` are ignored, because they originate from flushed instructions. The next state is IDLE.
- `stall` is always a contiguous run of ones from bit 0. A non-contiguous value is a design error.
- Downstream registers see Stop→NoStop at the boundary, so mem_wb inserts a bubble when `stall`=011111.
- Watchdog:
  - A 16-bit run counter increments each cycle `stall`≠0 and clears when `stall`=0 or in FLUSH.
  - When the counter reaches `WDOG_LIMIT`, `wdog_trip` sets. It stays set until reset.
- `stall_cycles` increments each cycle `stall`≠0 and saturates at 32'hFFFF_FFFF.

## Timing
- `stall` is combinational from the requests and the registered state, with zero latency: a request in cycle N stalls in cycle N.
- Exception sampled in cycle N gives `flush`=1 and a valid `new_pc` in cycle N+1. `flush` is registered.
- `new_pc` holds its value after FLUSH until the next exception.
- Reset values (asynchronous, while `reset`=0): state=IDLE, `flush`=0, `new_pc`=0, `wdog_trip`=0, `stall_cycles`=0, run counter=0. `stall`=0 during reset regardless of requests.
- Reset asserted mid-FLUSH aborts the flush immediately. After deassert the state is IDLE.
- An exception arriving together with `stallreq_mem`: the exception wins. The data-bus owner must cancel on `flush`.
- Back-to-back exception in the cycle of FLUSH is ignored. An exception in FLUSH+1 is accepted.

## Structure
- Shared package/header `global_define.vh` holds:
  - `Stop`/`NoStop`, `ZeroWord`.
  - Stall pattern constants: `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`.
  - Default `EXC_VECTOR`.
  - FSM state encodings.
- One natural sub-module: `stall_monitor`, which contains the run counter, watchdog, and saturating `stall_cycles`. Its only input is `stall`≠0 plus the FLUSH qualifier.
- The priority encoder and FSM stay in `pipe_ctrl`.

## Test plan
- Reset: hold `reset`=0 with all requests=1. Required: `stall`=0, `flush`=0, `new_pc`=0, `stall_cycles`=0, `wdog_trip`=0.
- Priority: assert `stallreq_if`+`stallreq_id`+`stallreq_ex` → 6'b001111. Add `stallreq_mem` → 6'b011111. Release all → 0 the same cycle.
- Exception:
  - `except_valid`=1, `except_is_eret`=0, with `stallreq_mem`=1 in cycle N. Required: `stall`=0 in N, then `flush`=1 and `new_pc`=32'hBFC0_0380 in N+1, then `flush`=0 in N+2.
  - Repeat with eret and `cp0_epc`=32'h8000_1234. Required: `new_pc`=32'h8000_1234.
- Flush shadow: `except_valid` held for 3 cycles. Required: `flush` pulses in N+1 and again in N+3, never in N+2.
- Watchdog with `WDOG_LIMIT`=8:
  - `stallreq_ex` held 7 cycles. Required: no trip.
  - Hold 8 cycles. Required: `wdog_trip`=1, which stays 1 after the request drops.
  - Required: `stall_cycles` equals the total number of stalled cycles.
- Reset mid-operation: assert `reset`=0 during FLUSH. Required: `flush`=0 immediately, and no flush pulse after deassert.
